vga_framebuffer: RTL and testbench

VGA_FRAMEBUFFER -- requirements
Module: vga_framebuffer

---
 rtl/vga_framebuffer_pkg.sv | 45 ++++
 rtl/vga_fb_bank.sv | 28 ++
 rtl/vga_framebuffer.sv | 165 ++++++++++++++++
 tb/tb_vga_framebuffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_framebuffer_pkg.sv
// rtl/vga_framebuffer_pkg.sv - command encodings, bus field positions and palette defaults
package vga_framebuffer_pkg;

  typedef enum logic [1:0] {
    CMD_PIXEL   = 2'd0,
    CMD_PALETTE = 2'd1,
    CMD_CLEAR   = 2'd2,
    CMD_SWAP    = 2'd3
  } vga_cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int RGB_W         = 12;
  localparam int COORD_W       = 10;
  localparam int PIX_X_LSB     = 0;
  localparam int PIX_Y_LSB     = 10;
  localparam int PIX_IDX_LSB   = 20;
  localparam int PAL_DATA_LSB  = 0;
  localparam int PAL_ENTRY_LSB = 12;

  localparam logic [RGB_W-1:0] PAL_DEF0      = 12'h000;
  localparam logic [RGB_W-1:0] PAL_DEF1      = 12'hFFF;
  localparam logic [RGB_W-1:0] PAL_DEF2      = 12'hF00;
  localparam logic [RGB_W-1:0] PAL_DEF3      = 12'h0F0;
  localparam logic [RGB_W-1:0] PAL_DEF_OTHER = 12'h00F;

  function automatic logic [RGB_W-1:0] default_palette(input int idx);
    case (idx)
      0:       return PAL_DEF0;
      1:       return PAL_DEF1;
      2:       return PAL_DEF2;
      3:       return PAL_DEF3;
      default: return PAL_DEF_OTHER;
    endcase
  endfunction

  // A one-entry memory still needs a one-bit address port.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/vga_fb_bank.sv
// rtl/vga_fb_bank.sv - simple dual-port frame buffer RAM, one write port, one registered read port
module vga_fb_bank
  import vga_framebuffer_pkg::*;
#(
  parameter int DEPTH = 480000,
  parameter int WIDTH = 2,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage is deliberately unreset so it maps onto block RAM; read is read-first.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_framebuffer.sv
// rtl/vga_framebuffer.sv - double-buffered paletted frame buffer with clear engine and vblank swap
module vga_framebuffer
  import vga_framebuffer_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 800,
  parameter int DISPLAY_HEIGHT = 600,
  parameter int BPP            = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       x,
  input  logic [9:0]        y,
  input  logic [31:0]       bus_wdata,
  input  logic [1:0]        vga_cmd,
  input  logic              vga_we,
  input  logic              frame_trig,
  output logic [RGB_W-1:0]  colour_out,
  output logic              busy,
  output logic              front_sel
);

  localparam int          DEPTH = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int          AW    = addr_width(DEPTH);
  localparam int          PAL_N = 1 << BPP;
  localparam logic [10:0] W11   = 11'(DISPLAY_WIDTH);
  localparam logic [10:0] H11   = 11'(DISPLAY_HEIGHT);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  vga_cmd_e         cmd;
  logic             cmd_ok;
  logic [COORD_W-1:0] pix_x, pix_y;
  logic [BPP-1:0]   pix_idx, pal_entry;
  logic             pix_in_range, rd_in_range;
  logic [AW-1:0]    pix_addr, rd_addr;

  clr_state_e       state_q;
  logic [AW-1:0]    clr_addr_q;
  logic [BPP-1:0]   clr_idx_q;
  logic             busy_q, front_sel_q, swap_pending_q;
  logic             front_sel_d, swap_pending_d;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [BPP-1:0]   wr_data;
  logic [BPP-1:0]   rdata0, rdata1, s1_idx;
  logic             s1_valid_q, s1_sel_q;
  logic [RGB_W-1:0] palette_q [PAL_N];
  logic [RGB_W-1:0] colour_out_q;

  assign cmd       = vga_cmd_e'(vga_cmd);
  assign cmd_ok    = vga_we && !busy_q;
  assign pix_x     = bus_wdata[PIX_X_LSB +: COORD_W];
  assign pix_y     = bus_wdata[PIX_Y_LSB +: COORD_W];
  assign pix_idx   = bus_wdata[PIX_IDX_LSB +: BPP];
  assign pal_entry = bus_wdata[PAL_ENTRY_LSB +: BPP];

  // Out-of-range coordinates are rejected outright so they never wrap into the next line.
  assign pix_in_range = ({1'b0, pix_x} < W11) && ({1'b0, pix_y} < H11);
  assign pix_addr     = AW'(pix_y) * AW'(DISPLAY_WIDTH) + AW'(pix_x);
  assign rd_in_range  = (x < W11) && ({1'b0, y} < H11);
  assign rd_addr      = rd_in_range ? (AW'(y) * AW'(DISPLAY_WIDTH) + AW'(x)) : '0;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = pix_addr;
    wr_data = pix_idx;
    if (state_q == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr_q;
      wr_data = clr_idx_q;
    end else if (cmd_ok && cmd == CMD_PIXEL && pix_in_range) begin
      wr_en = 1'b1;
    end
  end

  // Swap requests are latched even while clearing; the toggle waits for an idle vblank.
  always_comb begin
    front_sel_d    = front_sel_q;
    swap_pending_d = swap_pending_q;
    if (frame_trig && swap_pending_q && !busy_q) begin
      front_sel_d    = ~front_sel_q;
      swap_pending_d = 1'b0;
    end
    if (vga_we && cmd == CMD_SWAP) swap_pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      clr_addr_q     <= '0;
      clr_idx_q      <= '0;
      busy_q         <= 1'b0;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      case (state_q)
        ST_IDLE: begin
          if (cmd_ok && cmd == CMD_CLEAR) begin
            state_q    <= ST_CLEAR;
            busy_q     <= 1'b1;
            clr_addr_q <= '0;
            clr_idx_q  <= bus_wdata[BPP-1:0];
          end
        end
        ST_CLEAR: begin
          if (clr_addr_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + AW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PAL_N; i++) palette_q[i] <= default_palette(i);
    end else if (cmd_ok && cmd == CMD_PALETTE) begin
      palette_q[pal_entry] <= bus_wdata[PAL_DATA_LSB +: RGB_W];
    end
  end

  // Writes always go to the back buffer, i.e. the one not being displayed.
  vga_fb_bank #(.DEPTH(DEPTH), .WIDTH(BPP), .AW(AW)) u_bank0 (
    .clk     (clk),
    .we_i    (wr_en && front_sel_q),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rdata0)
  );

  vga_fb_bank #(.DEPTH(DEPTH), .WIDTH(BPP), .AW(AW)) u_bank1 (
    .clk     (clk),
    .we_i    (wr_en && !front_sel_q),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rdata1)
  );

  assign s1_idx = s1_sel_q ? rdata1 : rdata0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_sel_q     <= 1'b0;
      colour_out_q <= '0;
    end else begin
      s1_valid_q   <= rd_in_range;
      s1_sel_q     <= front_sel_q;
      colour_out_q <= s1_valid_q ? palette_q[s1_idx] : '0;
    end
  end

  assign colour_out = colour_out_q;
  assign busy       = busy_q;
  assign front_sel  = front_sel_q;

endmodule

// File: tb/tb_vga_framebuffer.sv
// tb/tb_vga_framebuffer.sv - scoreboard bench for vga_framebuffer on an 8x4 display
module tb_vga_framebuffer;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic [31:0] bus_wdata = '0;
  logic [1:0]  vga_cmd = '0;
  logic        vga_we = 1'b0;
  logic        frame_trig = 1'b0;
  logic [11:0] colour_out;
  logic        busy;
  logic        front_sel;

  int n_vec = 0;
  int n_bad = 0;
  int busy_cycles = 0;

  logic rd_issue = 1'b0;
  logic rd_p1 = 1'b0;
  logic rd_p2 = 1'b0;
  logic [11:0] exp_q[$];
  string       name_q[$];

  vga_framebuffer #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .BPP(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .y          (y),
    .bus_wdata  (bus_wdata),
    .vga_cmd    (vga_cmd),
    .vga_we     (vga_we),
    .frame_trig (frame_trig),
    .colour_out (colour_out),
    .busy       (busy),
    .front_sel  (front_sel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_p1 <= rd_issue;
    rd_p2 <= rd_p1;
  end

  always @(negedge clk) if (busy) busy_cycles++;

  // Monitor: every read reaches colour_out two edges after issue.
  always @(negedge clk) begin
    if (rd_p2) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_read: colour_out=%h with empty scoreboard", colour_out);
      end else begin
        automatic logic [11:0] e = exp_q.pop_front();
        automatic string       n = name_q.pop_front();
        if (colour_out !== e) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", n, colour_out, e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] c, input logic [31:0] d);
    vga_cmd = c; bus_wdata = d; vga_we = 1'b1;
    tick();
    vga_we = 1'b0;
  endtask

  task automatic trig();
    frame_trig = 1'b1;
    tick();
    frame_trig = 1'b0;
  endtask

  task automatic rd(input int xx, input int yy, input logic [11:0] e, input string n);
    x = 11'(xx); y = 10'(yy);
    exp_q.push_back(e);
    name_q.push_back(n);
    rd_issue = 1'b1;
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) tick();
    chk("clear_terminates", {31'b0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] pix(input int px, input int py, input int idx);
    return (32'(idx) << 20) | (32'(py) << 10) | 32'(px);
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_colour", {20'b0, colour_out}, 32'h000);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_front", {31'b0, front_sel}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    cmd(2'd2, 32'd0);
    wait_idle();
    cmd(2'd3, 32'd0);
    trig();
    chk("init_swap_a", {31'b0, front_sel}, 32'd1);
    cmd(2'd2, 32'd0);
    wait_idle();
    cmd(2'd3, 32'd0);
    trig();
    chk("init_swap_b", {31'b0, front_sel}, 32'd0);
    rd(0, 0, 12'h000, "read_0_0");

    cmd(2'd0, pix(5, 3, 1));
    cmd(2'd3, 32'd0);
    trig();
    chk("swap_after_pixel", {31'b0, front_sel}, 32'd1);
    rd(5, 3, 12'hFFF, "pixel_5_3");
    rd(6, 3, 12'h000, "pixel_6_3");
    tick(3);
    cmd(2'd1, (32'd1 << 12) | 32'hABC);
    rd(5, 3, 12'hABC, "palette_abc");
    tick(3);
    cmd(2'd1, (32'd5 << 12) | 32'h123);
    rd(5, 3, 12'h123, "palette_entry_wrap");
    tick(3);

    cmd(2'd0, pix(W, 0, 3));
    cmd(2'd0, pix(800, 0, 3));
    cmd(2'd0, pix(0, H, 3));
    cmd(2'd0, pix(0, 600, 3));
    cmd(2'd0, pix(W - 1, 0, 2));
    cmd(2'd3, 32'd0);
    trig();
    chk("swap_to_buf0", {31'b0, front_sel}, 32'd0);
    rd(0, 1, 12'h000, "no_wrap_0_1");
    rd(0, 0, 12'h000, "no_wrap_0_0");
    rd(W - 1, 0, 12'hF00, "last_column");
    rd(W, 0, 12'h000, "blank_x_eq_w");
    rd(900, 0, 12'h000, "blank_x_900");
    rd(0, H, 12'h000, "blank_y_eq_h");
    rd(W - 1, H - 1, 12'h000, "last_address");
    tick(3);

    busy_cycles = 0;
    cmd(2'd2, 32'd2);
    chk("busy_after_strobe", {31'b0, busy}, 32'd1);
    cmd(2'd0, pix(0, 0, 3));
    cmd(2'd1, (32'd2 << 12) | 32'h0F0);
    cmd(2'd3, 32'd0);
    trig();
    chk("swap_deferred", {31'b0, front_sel}, 32'd0);
    wait_idle();
    chk("clear_duration", busy_cycles, 32'd32);
    trig();
    chk("swap_after_busy", {31'b0, front_sel}, 32'd1);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        rd(xx, yy, 12'hF00, "clear_fill");
    tick(3);

    cmd(2'd2, 32'd3);
    tick(5);
    rst = 1'b0;
    #2;
    chk("rst_async_busy", {31'b0, busy}, 32'd0);
    chk("rst_async_colour", {20'b0, colour_out}, 32'h000);
    chk("rst_front", {31'b0, front_sel}, 32'd0);
    tick(2);
    rst = 1'b1;
    cmd(2'd0, pix(1, 1, 0));
    cmd(2'd0, pix(2, 1, 1));
    cmd(2'd3, 32'd0);
    trig();
    chk("swap_after_rst", {31'b0, front_sel}, 32'd1);
    rd(1, 1, 12'h000, "post_rst_write");
    rd(2, 1, 12'hFFF, "palette_reset");
    rd(3, 1, 12'hF00, "post_rst_untouched");
    tick(4);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
